// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared types and constants for the ID/EX pipeline stage.
//   XLEN / CTRL_W      : datapath and opaque control-bundle widths
//   REG_ZERO           : architectural zero-register index (never a hazard)
//   ZERO_WORD          : all-zero datapath word
//   CTRL_*             : field positions inside the opaque ex_ctrl bundle
//   idex_payload_t     : everything decode hands to EX for one instruction
//   sat_inc32()        : saturating increment for the optional perf counters
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;

    localparam logic [4:0]      REG_ZERO  = 5'd0;
    localparam logic [XLEN-1:0] ZERO_WORD = '0;

    // Layout of ex_ctrl; the stage itself never looks inside it.
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_BRANCH_BIT = 4;
    localparam int CTRL_JUMP_BIT   = 5;
    localparam int CTRL_WB_SEL_LSB = 6;
    localparam int CTRL_WB_SEL_W   = 2;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              uses_rs1;
        logic              uses_rs2;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [CTRL_W-1:0] ctrl;
    } idex_payload_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Valid/ready instruction bus between pipeline stages.
//   valid : producer holds a valid instruction
//   ready : consumer accepts this cycle
//   data  : instruction payload (idex_payload_t)
// master = producer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic          valid;
    logic          ready;
    idex_payload_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// ---------------------------------------------------------------------------
// idex_hazard_detect
// Pure combinational load-use compare between the instruction held in EX and
// the one waiting in decode.
//   ex_valid, ex_mem_read, ex_rd           : instruction currently in EX
//   id_valid, id_uses_rs1/2, id_rs1/2      : instruction waiting in decode
//   hazard                                 : decode must wait one cycle
// ---------------------------------------------------------------------------
module idex_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    // Only operands the instruction really reads can create a dependency.
    assign rs1_hit = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 & (id_rs2 == ex_rd);

    // A load into x0 never produces a value worth waiting for.
    assign hazard = ex_valid & ex_mem_read & (ex_rd != REG_ZERO)
                  & (rs1_hit | rs2_hit) & id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use interlock and redirect flush.
//   clk, rst_n (sync, active-low), flush (redirect kills stage + incoming)
//   id_if  (slave)  : decoded instruction from ID, id_if.ready back-pressure
//   ex_if  (master) : held instruction to EX, ex_if.ready = EX consumes it
//   stall_o         : load-use hazard this cycle (fetch/PC hold)
// Optional macro IDEX_PERF_CNT_EN adds saturating counters perf_accept,
// perf_bubble (load-use bubbles) and perf_flush (flushes killing a valid
// instruction).
// ---------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    id_ex_stage_if.slave  id_if,
    id_ex_stage_if.master ex_if,
    output logic          stall_o
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]   perf_accept,
    output logic [31:0]   perf_bubble,
    output logic [31:0]   perf_flush
`endif
);

    logic          ex_valid_q;
    idex_payload_t ex_q;
    idex_payload_t ex_out;
    logic          hazard;
    logic          ready;
    logic          accept;
    logic          bubble;

    idex_hazard_detect u_hazard (
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_q.mem_read),
        .ex_rd       (ex_q.rd),
        .id_valid    (id_if.valid),
        .id_uses_rs1 (id_if.data.uses_rs1),
        .id_uses_rs2 (id_if.data.uses_rs2),
        .id_rs1      (id_if.data.rs1),
        .id_rs2      (id_if.data.rs2),
        .hazard      (hazard)
    );

    // rst_n gates ready so decode never sees a handshake while in reset.
    assign ready       = rst_n & ~flush & ~hazard & (~ex_valid_q | ex_if.ready);
    assign id_if.ready = ready;
    assign accept      = id_if.valid & ready;
    // Covers both the load-use bubble and a plain empty upstream.
    assign bubble      = ex_if.ready & ex_valid_q & ~accept;
    assign stall_o     = hazard;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (flush) begin
            ex_valid_q <= 1'b0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_q       <= id_if.data;
        end else if (bubble) begin
            ex_valid_q <= 1'b0;
        end
    end

    // Side-effecting controls are masked so a bubble can never write state.
    always_comb begin
        ex_out           = ex_q;
        ex_out.reg_write = ex_q.reg_write & ex_valid_q;
        ex_out.mem_read  = ex_q.mem_read  & ex_valid_q;
        ex_out.mem_write = ex_q.mem_write & ex_valid_q;
    end

    assign ex_if.valid = ex_valid_q;
    assign ex_if.data  = ex_out;

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_accept <= '0;
            perf_bubble <= '0;
            perf_flush  <= '0;
        end else begin
            if (accept)
                perf_accept <= sat_inc32(perf_accept);
            // Only bubbles caused by the interlock, not an idle upstream.
            if (!flush && bubble && hazard)
                perf_bubble <= sat_inc32(perf_bubble);
            if (flush && ex_valid_q)
                perf_flush <= sat_inc32(perf_flush);
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic stall_o;
    int   checks = 0;
    int   errors = 0;

    id_ex_stage_if id_bus ();
    id_ex_stage_if ex_bus ();

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] perf_accept, perf_bubble, perf_flush;
`endif

    id_ex_stage dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .id_if   (id_bus),
        .ex_if   (ex_bus),
        .stall_o (stall_o)
`ifdef IDEX_PERF_CNT_EN
        ,
        .perf_accept (perf_accept),
        .perf_bubble (perf_bubble),
        .perf_flush  (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // What the stage should be holding, plus event tallies.
    logic          m_valid = 1'b0;
    idex_payload_t m_p     = '0;
    int unsigned   m_acc = 0, m_bub = 0, m_fl = 0;

    // EX holds a load writing a real register that decode's instruction reads.
    function automatic logic ref_hazard();
        if (!(m_valid && m_p.mem_read && m_p.rd != 5'd0 && id_bus.valid)) return 1'b0;
        return (id_bus.data.uses_rs1 && id_bus.data.rs1 == m_p.rd) ||
               (id_bus.data.uses_rs2 && id_bus.data.rs2 == m_p.rd);
    endfunction

    function automatic logic ref_ready();
        return rst_n && !flush && !ref_hazard() && (!m_valid || ex_bus.ready);
    endfunction

    function automatic idex_payload_t ref_out();
        idex_payload_t o;
        o = m_p;
        if (!m_valid) begin
            o.reg_write = 1'b0;
            o.mem_read  = 1'b0;
            o.mem_write = 1'b0;
        end
        return o;
    endfunction

    // Advance model by one clock using the inputs currently applied, then
    // step the DUT clock; returns 1 ns after the edge.
    task automatic tick();
        logic hz, acc;
        hz  = ref_hazard();
        acc = id_bus.valid && ref_ready();
        if (!rst_n) begin
            m_valid = 1'b0; m_p = '0; m_acc = 0; m_bub = 0; m_fl = 0;
        end else if (flush) begin
            if (m_valid) m_fl++;
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1; m_p = id_bus.data; m_acc++;
        end else if (m_valid && ex_bus.ready) begin
            if (hz) m_bub++;
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic idex_payload_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [4:0] rd,
                                         input logic u1, input logic u2, input logic rw,
                                         input logic mr, input logic mw);
        idex_payload_t p;
        p.pc = pc; p.imm = $urandom; p.rs1_data = $urandom; p.rs2_data = $urandom;
        p.rs1 = rs1; p.rs2 = rs2; p.rd = rd; p.uses_rs1 = u1; p.uses_rs2 = u2;
        p.reg_write = rw; p.mem_read = mr; p.mem_write = mw;
        p.ctrl = CTRL_W'($urandom);
        return p;
    endfunction

    task automatic idle_inputs();
        id_bus.valid = 1'b0;
        id_bus.data  = '0;
        ex_bus.ready = 1'b1;
        flush        = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        id_bus.valid = 1'b1;
        id_bus.data  = mk(32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0);
        tick(); tick();
        checks++;
        if (ex_bus.valid !== 1'b0 || ex_bus.data !== idex_payload_t'(0)) begin
            errors++; $display("FAIL reset_out: valid=%b data=%h want 0", ex_bus.valid, ex_bus.data);
        end
        checks++;
        if (id_bus.ready !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_ready: ready=%b stall=%b want 0/0", id_bus.ready, stall_o);
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_alu_stream();
        logic [31:0] pcs [4];
        for (int i = 0; i < 4; i++) pcs[i] = 32'h200 + 32'(i * 4);
        for (int i = 0; i < 4; i++) begin
            id_bus.valid = 1'b1;
            id_bus.data  = mk(pcs[i], 5'd1, 5'd2, 5'(10 + i), 1, 1, 1, 0, 0);
            #1;
            checks++;
            if (stall_o !== 1'b0 || id_bus.ready !== 1'b1) begin
                errors++; $display("FAIL alu_stall[%0d]: stall=%b ready=%b want 0/1", i, stall_o, id_bus.ready);
            end
            tick();
            checks++;
            if (ex_bus.valid !== 1'b1 || ex_bus.data.pc !== pcs[i]) begin
                errors++; $display("FAIL alu_pc[%0d]: valid=%b pc=%h want 1/%h", i, ex_bus.valid, ex_bus.data.pc, pcs[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_use();
        idex_payload_t add;
        id_bus.valid = 1'b1;
        id_bus.data  = mk(32'h300, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0);   // LW x5
        tick();
        add = mk(32'h304, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0, 0);            // ADD x6,x5,x1
        id_bus.data = add;
        #1;
        checks++;
        if (stall_o !== 1'b1 || id_bus.ready !== 1'b0) begin
            errors++; $display("FAIL lu_stall: stall=%b ready=%b want 1/0", stall_o, id_bus.ready);
        end
        tick();
        checks++;
        if (ex_bus.valid !== 1'b0 || ex_bus.data.reg_write !== 1'b0) begin
            errors++; $display("FAIL lu_bubble: valid=%b rw=%b want 0/0", ex_bus.valid, ex_bus.data.reg_write);
        end
        checks++;
        if (stall_o !== 1'b0 || id_bus.ready !== 1'b1) begin
            errors++; $display("FAIL lu_release: stall=%b ready=%b want 0/1", stall_o, id_bus.ready);
        end
        tick();
        checks++;
        if (ex_bus.valid !== 1'b1 || ex_bus.data !== add) begin
            errors++; $display("FAIL lu_accept: valid=%b data=%h want 1/%h", ex_bus.valid, ex_bus.data, add);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_no_hazard_cases();
        id_bus.valid = 1'b1;
        id_bus.data  = mk(32'h400, 5'd1, 5'd0, 5'd0, 1, 0, 1, 1, 0);   // LW x0
        tick();
        id_bus.data  = mk(32'h404, 5'd0, 5'd0, 5'd7, 1, 1, 1, 0, 0);   // reads x0
        #1;
        checks++;
        if (stall_o !== 1'b0 || id_bus.ready !== 1'b1) begin
            errors++; $display("FAIL x0_nostall: stall=%b ready=%b want 0/1", stall_o, id_bus.ready);
        end
        tick();
        id_bus.data  = mk(32'h408, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1, 0);   // LW x5
        tick();
        id_bus.data  = mk(32'h40c, 5'd5, 5'd3, 5'd8, 0, 1, 1, 0, 0);   // rs1=5 not used
        #1;
        checks++;
        if (stall_o !== 1'b0 || id_bus.ready !== 1'b1) begin
            errors++; $display("FAIL unused_rs1: stall=%b ready=%b want 0/1", stall_o, id_bus.ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        idex_payload_t a, b;
        a = mk(32'h500, 5'd1, 5'd2, 5'd9, 1, 1, 1, 0, 1);
        b = mk(32'h504, 5'd3, 5'd4, 5'd10, 1, 1, 1, 0, 0);
        id_bus.valid = 1'b1; id_bus.data = a;
        tick();
        id_bus.data = b; ex_bus.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (id_bus.ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready[%0d]: ready=%b want 0", i, id_bus.ready);
            end
            tick();
            checks++;
            if (ex_bus.valid !== 1'b1 || ex_bus.data !== a) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%b pc=%h want 1/%h", i, ex_bus.valid, ex_bus.data.pc, a.pc);
            end
        end
        ex_bus.ready = 1'b1;
        tick();
        checks++;
        if (ex_bus.valid !== 1'b1 || ex_bus.data !== b) begin
            errors++; $display("FAIL bp_resume: valid=%b pc=%h want 1/%h", ex_bus.valid, ex_bus.data.pc, b.pc);
        end
        id_bus.valid = 1'b0;
        tick();
        checks++;
        if (ex_bus.valid !== 1'b0) begin
            errors++; $display("FAIL bp_nodup: valid=%b want 0", ex_bus.valid);
        end
        idle_inputs();
    endtask

    task automatic test_flush_in_stall();
`ifdef IDEX_PERF_CNT_EN
        logic [31:0] f0;
`endif
        id_bus.valid = 1'b1;
        id_bus.data  = mk(32'h600, 5'd1, 5'd0, 5'd5, 1, 0, 1, 1, 0);   // LW x5
        tick();
        id_bus.data  = mk(32'h604, 5'd5, 5'd5, 5'd6, 1, 1, 1, 0, 0);
`ifdef IDEX_PERF_CNT_EN
        f0 = perf_flush;
`endif
        flush = 1'b1;
        #1;
        checks++;
        if (id_bus.ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: ready=%b want 0", id_bus.ready);
        end
        tick();
        checks++;
        if (ex_bus.valid !== 1'b0 || ex_bus.data.reg_write !== 1'b0 || ex_bus.data.pc !== 32'h600) begin
            errors++; $display("FAIL flush_kill: valid=%b rw=%b pc=%h want 0/0/00000600",
                               ex_bus.valid, ex_bus.data.reg_write, ex_bus.data.pc);
        end
`ifdef IDEX_PERF_CNT_EN
        checks++;
        if (perf_flush !== f0 + 32'd1) begin
            errors++; $display("FAIL perf_flush: got %0d want %0d", perf_flush, f0 + 32'd1);
        end
`endif
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        id_bus.valid = 1'b1;
        id_bus.data  = mk(32'h700, 5'd1, 5'd0, 5'd4, 1, 0, 1, 1, 0);
        tick();
        id_bus.data  = mk(32'h704, 5'd4, 5'd0, 5'd6, 1, 0, 1, 0, 0);
        rst_n = 1'b0;
        tick();
        checks++;
        if (ex_bus.valid !== 1'b0 || ex_bus.data !== idex_payload_t'(0) || stall_o !== 1'b0 || id_bus.ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid: valid=%b data=%h stall=%b ready=%b want all 0",
                               ex_bus.valid, ex_bus.data, stall_o, id_bus.ready);
        end
`ifdef IDEX_PERF_CNT_EN
        checks++;
        if (perf_accept !== 0 || perf_bubble !== 0 || perf_flush !== 0) begin
            errors++; $display("FAIL rst_perf: %0d %0d %0d want 0 0 0", perf_accept, perf_bubble, perf_flush);
        end
`endif
        rst_n = 1'b1;
        tick();
        checks++;
        if (ex_bus.valid !== 1'b1 || ex_bus.data.pc !== 32'h704) begin
            errors++; $display("FAIL rst_resume: valid=%b pc=%h want 1/00000704", ex_bus.valid, ex_bus.data.pc);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(0, 59) != 0);
            flush        = ($urandom_range(0, 15) == 0);
            ex_bus.ready = ($urandom_range(0, 3) != 0);
            id_bus.valid = ($urandom_range(0, 3) != 0);
            id_bus.data  = mk($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                              5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                              1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            checks++;
            if (stall_o !== ref_hazard() || id_bus.ready !== ref_ready()) begin
                errors++; $display("FAIL rnd_comb[%0d]: stall=%b ready=%b want %b/%b",
                                   i, stall_o, id_bus.ready, ref_hazard(), ref_ready());
            end
            tick();
            checks++;
            if (ex_bus.valid !== m_valid || ex_bus.data !== ref_out()) begin
                errors++; $display("FAIL rnd_out[%0d]: valid=%b data=%h want %b/%h",
                                   i, ex_bus.valid, ex_bus.data, m_valid, ref_out());
            end
`ifdef IDEX_PERF_CNT_EN
            checks++;
            if (perf_accept !== m_acc || perf_bubble !== m_bub || perf_flush !== m_fl) begin
                errors++; $display("FAIL rnd_perf[%0d]: %0d %0d %0d want %0d %0d %0d",
                                   i, perf_accept, perf_bubble, perf_flush, m_acc, m_bub, m_fl);
            end
`endif
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_load_use();
        test_no_hazard_cases();
        test_backpressure();
        test_flush_in_stall();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
